// File: rtl/chargen_pkg.sv
// Shared constants for the character generator: ASCII defaults, active-low
// flag encodings and the next-character step function.
package chargen_pkg;

   localparam logic [7:0] ASCII_A = 8'h61;
   localparam logic [7:0] ASCII_Z = 8'h7A;

   typedef enum logic {
      AL_TRUE  = 1'b0,
      AL_FALSE = 1'b1
   } act_low_e;

   // Wraps to first once the last character of the range has been shown.
   function automatic logic [7:0] next_char(
      input logic [7:0] cur,
      input logic [7:0] first,
      input logic [7:0] last
   );
      if (cur == last) begin
         return first;
      end
      return cur + 8'd1;
   endfunction

endpackage

// File: rtl/chargen.sv
// ASCII character generator: presents FIRSTCHAR..LASTCHAR in order, advancing
// one character per completed ready/valid handshake.
module chargen
   import chargen_pkg::*;
#(
   parameter logic [7:0] FIRSTCHAR = ASCII_A,
   parameter logic [7:0] LASTCHAR  = ASCII_Z
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       ready_n,
   output logic       valid_n,
   output logic [7:0] port
);

   logic       ready;
   logic       valid_q, valid_d;
   logic [7:0] char_q, char_d;

   assign ready = (ready_n == AL_TRUE);

   // valid echoes ready one cycle late, so a character is only consumed once
   // it has been presented with valid for a full cycle.
   always_comb begin
      valid_d = ready;
      char_d  = char_q;
      if (ready && valid_q) begin
         char_d = next_char(char_q, FIRSTCHAR, LASTCHAR);
      end
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         char_q  <= FIRSTCHAR;
         valid_q <= 1'b0;
      end else begin
         char_q  <= char_d;
         valid_q <= valid_d;
      end
   end

   assign valid_n = valid_q ? AL_TRUE : AL_FALSE;
   assign port    = char_q;

endmodule

// File: tb/tb_chargen.sv
// Directed self-checking bench for chargen: short-range, default-range and
// single-character instances driven from shared reset/ready stimulus.
module tb_chargen;

   logic       clk = 1'b0;
   logic       n_rst = 1'b1;
   logic       ready_n = 1'b1;
   logic       vn_c, vn_d, vn_k;
   logic [7:0] p_c, p_d, p_k;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   chargen #(.FIRSTCHAR(8'h61), .LASTCHAR(8'h63)) dut_c (
      .clk(clk), .n_rst(n_rst), .ready_n(ready_n), .valid_n(vn_c), .port(p_c)
   );

   chargen dut_d (
      .clk(clk), .n_rst(n_rst), .ready_n(ready_n), .valid_n(vn_d), .port(p_d)
   );

   chargen #(.FIRSTCHAR(8'h78), .LASTCHAR(8'h78)) dut_k (
      .clk(clk), .n_rst(n_rst), .ready_n(ready_n), .valid_n(vn_k), .port(p_k)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_rst   = 1'b1;
      ready_n = 1'b0;
      step();
      checks++;
      if (p_c !== 8'h61 || vn_c !== 1'b1) begin
         failures++;
         $display("FAIL reset_c: port=%h valid_n=%b expected port=61 valid_n=1", p_c, vn_c);
      end
      checks++;
      if (p_d !== 8'h61 || vn_d !== 1'b1) begin
         failures++;
         $display("FAIL reset_d: port=%h valid_n=%b expected port=61 valid_n=1", p_d, vn_d);
      end
      checks++;
      if (p_k !== 8'h78 || vn_k !== 1'b1) begin
         failures++;
         $display("FAIL reset_k: port=%h valid_n=%b expected port=78 valid_n=1", p_k, vn_k);
      end
   endtask

   task automatic test_not_ready();
      n_rst   = 1'b0;
      ready_n = 1'b1;
      step();
      checks++;
      if (p_c !== 8'h61 || vn_c !== 1'b1) begin
         failures++;
         $display("FAIL not_ready: port=%h valid_n=%b expected port=61 valid_n=1", p_c, vn_c);
      end
   endtask

   task automatic test_streaming();
      logic [7:0] exp [3];
      exp[0] = 8'h61; exp[1] = 8'h62; exp[2] = 8'h63;
      ready_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (p_c !== exp[i] || vn_c !== 1'b0) begin
            failures++;
            $display("FAIL stream[%0d]: port=%h valid_n=%b expected port=%h valid_n=0",
                     i, p_c, vn_c, exp[i]);
         end
      end
   endtask

   task automatic test_stall_wrap();
      ready_n = 1'b1;
      step();
      checks++;
      if (p_c !== 8'h63 || vn_c !== 1'b1) begin
         failures++;
         $display("FAIL stall_hold: port=%h valid_n=%b expected port=63 valid_n=1", p_c, vn_c);
      end
      ready_n = 1'b0;
      step();
      checks++;
      if (p_c !== 8'h63 || vn_c !== 1'b0) begin
         failures++;
         $display("FAIL stall_represent: port=%h valid_n=%b expected port=63 valid_n=0", p_c, vn_c);
      end
      step();
      checks++;
      if (p_c !== 8'h61 || vn_c !== 1'b0) begin
         failures++;
         $display("FAIL wrap: port=%h valid_n=%b expected port=61 valid_n=0", p_c, vn_c);
      end
   endtask

   task automatic test_reset_mid();
      step();
      checks++;
      if (p_c !== 8'h62 || vn_c !== 1'b0) begin
         failures++;
         $display("FAIL pre_mid_reset: port=%h valid_n=%b expected port=62 valid_n=0", p_c, vn_c);
      end
      n_rst = 1'b1;
      step();
      checks++;
      if (p_c !== 8'h61 || vn_c !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid: port=%h valid_n=%b expected port=61 valid_n=1", p_c, vn_c);
      end
      checks++;
      if (p_k !== 8'h78) begin
         failures++;
         $display("FAIL const_k: port=%h expected 78", p_k);
      end
   endtask

   task automatic test_default_stream();
      logic [7:0] exp_d, exp_c;
      n_rst   = 1'b1;
      ready_n = 1'b0;
      step();
      n_rst = 1'b0;
      for (int i = 1; i <= 27; i++) begin
         step();
         exp_d = (i == 1) ? 8'h61 : 8'h61 + 8'((i - 1) % 26);
         exp_c = (i == 1) ? 8'h61 : 8'h61 + 8'((i - 1) % 3);
         checks++;
         if (p_d !== exp_d || vn_d !== 1'b0) begin
            failures++;
            $display("FAIL default_stream[%0d]: port=%h valid_n=%b expected port=%h valid_n=0",
                     i, p_d, vn_d, exp_d);
         end
         checks++;
         if (p_c !== exp_c) begin
            failures++;
            $display("FAIL short_stream[%0d]: port=%h expected %h", i, p_c, exp_c);
         end
         checks++;
         if (p_k !== 8'h78 || vn_k !== 1'b0) begin
            failures++;
            $display("FAIL const_stream[%0d]: port=%h valid_n=%b expected port=78 valid_n=0",
                     i, p_k, vn_k);
         end
      end
   endtask

   task automatic test_reset_at_last();
      // 25 more edges from "a" land dut_d on "z" with valid asserted.
      for (int i = 0; i < 25; i++) step();
      checks++;
      if (p_d !== 8'h7A || vn_d !== 1'b0) begin
         failures++;
         $display("FAIL at_last: port=%h valid_n=%b expected port=7a valid_n=0", p_d, vn_d);
      end
      n_rst = 1'b1;
      step();
      checks++;
      if (p_d !== 8'h61 || vn_d !== 1'b1) begin
         failures++;
         $display("FAIL reset_at_last: port=%h valid_n=%b expected port=61 valid_n=1", p_d, vn_d);
      end
      n_rst = 1'b0;
      step();
      checks++;
      if (p_d !== 8'h61 || vn_d !== 1'b0) begin
         failures++;
         $display("FAIL restart_latency: port=%h valid_n=%b expected port=61 valid_n=0", p_d, vn_d);
      end
      step();
      checks++;
      if (p_d !== 8'h62 || vn_d !== 1'b0) begin
         failures++;
         $display("FAIL restart_advance: port=%h valid_n=%b expected port=62 valid_n=0", p_d, vn_d);
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_not_ready();
      test_streaming();
      test_stall_wrap();
      test_reset_mid();
      test_default_stream();
      test_reset_at_last();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/chargen.md
CHARGEN -- requirements
Module: chargen

Interface
REQ-001 Parameter FIRSTCHAR, default 8'h61 ("a"), SHALL be the first character of the sequence and the reset value of port.
REQ-002 Parameter LASTCHAR, default 8'h7A ("z"), SHALL be the last character of the sequence before wrap.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 n_rst  input  1  SHALL be the reset; synchronous, active-high (asserted = 1), sampled on rising clk.
REQ-005 ready_n  input  1  SHALL be the consumer-ready strobe; active-low (0 = ready).
REQ-006 valid_n  output  1  SHALL be the data-valid flag; active-low (0 = valid); registered.
REQ-007 port  output  8  SHALL be the current ASCII character; registered.

Function
REQ-008 Internal "ready" = ~ready_n and "valid" = ~valid_n SHALL be used below.
REQ-009 On each rising clk with reset deasserted, valid SHALL be loaded with the current ready (one-cycle registered echo of ready).
REQ-010 On each rising clk with reset deasserted, port SHALL advance to the next character only if ready AND valid are both asserted before the edge (transfer completed); otherwise port SHALL hold.
REQ-011 Next character SHALL be port+1 when port != LASTCHAR, and FIRSTCHAR when port == LASTCHAR (wrap).
REQ-012 First cycle after ready asserts (valid still deasserted) SHALL NOT advance; the held character is presented with valid on the following cycle.
REQ-013 Deasserting ready SHALL deassert valid on the next edge and freeze port; the frozen character SHALL be re-presented, not skipped, when ready returns.
REQ-014 Continuous ready SHALL produce one new character per clock after the initial one-cycle latency.
REQ-015 Character arithmetic SHALL be unsigned 8-bit; FIRSTCHAR <= LASTCHAR is required of parameters; FIRSTCHAR == LASTCHAR SHALL hold port constant.
REQ-016 port SHALL never take a value outside [FIRSTCHAR, LASTCHAR].

Reset
REQ-017 With n_rst high at a rising edge, port SHALL become FIRSTCHAR and valid_n SHALL become 1 (not valid), regardless of ready_n.
REQ-018 Reset SHALL take priority over any simultaneous transfer, including mid-sequence and at LASTCHAR.
REQ-019 After reset release, the sequence SHALL restart from FIRSTCHAR with the REQ-012 latency.

Structure
REQ-020 ASCII defaults ("a", "z") and the active-low true/false constants SHALL live in the shared common package/include.
REQ-021 Implementation SHALL be a single flat module: one 8-bit character register, one valid register, next-character combinational logic; no sub-module.

Verification (LASTCHAR = "c" unless noted)
REQ-022 Reset: n_rst=1 one edge -> port="a", valid_n=1.
REQ-023 Not ready: after reset, ready_n=1, one edge -> port="a", valid_n=1.
REQ-024 Streaming: ready_n=0 for edges 1,2,3 -> port "a","b","c", valid_n=0 on each.
REQ-025 Stall and wrap: at "c", ready_n=1 one edge -> "c", valid_n=1; ready_n=0 -> "c", valid_n=0; next edge -> "a".
REQ-026 Reset mid-stream: at "b" with ready_n=0, n_rst=1 -> port="a", valid_n=1 on that edge.
REQ-027 Default params: ready_n=0 held 27 edges from reset -> "a".."z" then "a", no skips or repeats after first valid.
